// File: rtl/multi_cycle_ctrl_pkg.sv
// ============================================================================
// Module : multi_cycle_ctrl_pkg
// Brief  : Opcode, state, ALUOp and PCSrc encodings shared by the MulCPU control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package multi_cycle_ctrl_pkg;

  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EXE_AL = 4'd2;
  localparam logic [3:0] S_EXE_BR = 4'd3;
  localparam logic [3:0] S_EXE_LS = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB_AL  = 4'd6;
  localparam logic [3:0] S_WB_LD  = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;

  localparam logic [1:0] PCS_NEXT   = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JR     = 2'b10;
  localparam logic [1:0] PCS_JUMP   = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Opcodes that take the EXE_AL/WB_AL path and really write a register.
  function automatic logic is_alu_write(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
      OP_SLL, OP_SLT, OP_SLTIU: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
      OP_OR, OP_ORI:          return ALU_OR;
      OP_AND:                 return ALU_AND;
      OP_SLL:                 return ALU_SLL;
      OP_SLT:                 return ALU_SLT;
      OP_SLTIU:               return ALU_SLTU;
      default:                return ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_ctrl_decode.sv
// ============================================================================
// Module : multi_cycle_ctrl_decode
// Brief  : Combinational decode of (state, opcode, zero) into datapath controls.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multi_cycle_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [3:0]         cur_state,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic               RegWre,
  output logic               WrRegDSrc,
  output logic [1:0]         RegDst
);

  logic w_taken;

  assign w_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PCS_NEXT;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = '0;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = DST_RA;
    // Reset masks everything so a stale state can never strobe memory or the PC.
    if (!Reset) begin
      ALUSrcA   = (opcode == OP_SLL);
      ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_SLTIU) ||
                  (opcode == OP_LW)   || (opcode == OP_SW);
      ALUOp     = alu_op_of(opcode);
      ExtSel    = !((opcode == OP_ORI) || (opcode == OP_SLTIU));
      DBDataSrc = (opcode == OP_LW);
      WrRegDSrc = (opcode != OP_JAL);
      if (opcode == OP_JAL)
        RegDst = DST_RA;
      else if ((opcode == OP_ADDI) || (opcode == OP_ORI) ||
               (opcode == OP_SLTIU) || (opcode == OP_LW))
        RegDst = DST_RT;
      else
        RegDst = DST_RD;

      case (cur_state)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          if (is_jump(opcode)) begin
            PCWre  = 1'b1;
            PCSrc  = (opcode == OP_JR) ? PCS_JR : PCS_JUMP;
            RegWre = (opcode == OP_JAL);
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = w_taken ? PCS_BRANCH : PCS_NEXT;
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            mRD = 1'b1;
          end else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = is_alu_write(opcode);
        end
        S_WB_LD: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module : multi_cycle_ctrl
// Brief  : MulCPU multi-cycle control FSM (IF/ID/EXE/MEM/WB) with state register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic               RegWre,
  output logic               WrRegDSrc,
  output logic [1:0]         RegDst,
  output logic [3:0]         state
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  always_ff @(posedge CLK) begin
    if (Reset)
      r_state <= S_IF;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        if (is_jump(opcode))
          w_next_state = S_IF;
        else if (opcode == OP_HALT)
          w_next_state = S_HALT;
        else if (is_branch(opcode))
          w_next_state = S_EXE_BR;
        else if ((opcode == OP_LW) || (opcode == OP_SW))
          w_next_state = S_EXE_LS;
        else
          w_next_state = S_EXE_AL;
      end
      S_EXE_AL: w_next_state = S_WB_AL;
      S_EXE_BR: w_next_state = S_IF;
      S_EXE_LS: w_next_state = S_MEM;
      S_MEM:    w_next_state = (opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_AL:  w_next_state = S_IF;
      S_WB_LD:  w_next_state = S_IF;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IF;
    endcase
  end

  // While Reset is high the trace shows IF even before the first clock edge.
  assign state = Reset ? S_IF : r_state;

  multi_cycle_ctrl_decode #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .cur_state (r_state),
    .Reset     (Reset),
    .opcode    (opcode),
    .zero      (zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .mRD       (mRD),
    .mWR       (mWR),
    .DBDataSrc (DBDataSrc),
    .RegWre    (RegWre),
    .WrRegDSrc (WrRegDSrc),
    .RegDst    (RegDst)
  );

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// Module : tb_multi_cycle_ctrl
// Brief  : Self-checking bench for multi_cycle_ctrl: table, corner sequences, random.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_ctrl;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTIU = 6'b100111;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
  localparam logic [5:0] BNE = 6'b110101, J = 6'b111000, JR = 6'b111001;
  localparam logic [5:0] JAL = 6'b111010, HALT = 6'b111111;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multi_cycle_ctrl #(.OP_W(6), .ALUOP_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .RegWre(RegWre),
    .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .state(state)
  );

  // Observation vector: {state, PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB,
  //                      ALUOp, ExtSel, mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst}
  function automatic logic [21:0] observe();
    return {state, PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp,
            ExtSel, mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: instruction-level view ----------------
  function automatic int m_len(input logic [5:0] op);
    if (op == J || op == JAL || op == JR) return 2;
    if (op == BEQ || op == BNE)           return 3;
    if (op == LW)                         return 5;
    if (op == HALT)                       return 0;
    return 4;
  endfunction

  function automatic logic [3:0] m_state(input logic [5:0] op, input int idx);
    logic [3:0] alu_path [4] = '{4'd0, 4'd1, 4'd2, 4'd6};
    logic [3:0] lw_path  [5] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7};
    if (idx == 0) return 4'd0;
    if (idx == 1) return 4'd1;
    if (op == HALT)             return 4'd8;
    if (op == BEQ || op == BNE) return 4'd3;
    if (op == LW)               return lw_path[idx > 4 ? 4 : idx];
    if (op == SW)               return lw_path[idx > 3 ? 3 : idx];
    return alu_path[idx > 3 ? 3 : idx];
  endfunction

  function automatic logic [2:0] m_aluop(input logic [5:0] op);
    case (op)
      SUB, BEQ, BNE: return 3'b001;
      OR_, ORI:      return 3'b101;
      AND_:          return 3'b100;
      SLL:           return 3'b110;
      SLT:           return 3'b010;
      SLTIU:         return 3'b011;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic [21:0] model(input logic [5:0] op, input logic z, input int idx);
    logic       last, writes_alu, itype;
    logic [1:0] psrc, rdst;
    last       = (idx == m_len(op) - 1);
    writes_alu = op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU};
    itype      = op inside {ADDI, ORI, SLTIU, LW};
    psrc = 2'b00;
    if (last) begin
      if (op == J || op == JAL) psrc = 2'b11;
      else if (op == JR)        psrc = 2'b10;
      else if ((op == BEQ && z) || (op == BNE && !z)) psrc = 2'b01;
    end
    rdst = (op == JAL) ? 2'b00 : (itype ? 2'b01 : 2'b10);
    return {m_state(op, idx), last, psrc, idx == 0, idx == 0,
            op == SLL, op inside {ADDI, ORI, SLTIU, LW, SW}, m_aluop(op),
            !(op == ORI || op == SLTIU),
            op == LW && idx == 3, op == SW && idx == 3, op == LW,
            (op == JAL && idx == 1) || (op == LW && idx == 4) || (writes_alu && idx == 3),
            op != JAL, rdst};
  endfunction

  // Runs one instruction from IF until the FSM is back in IF (bounded), checking each cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, output int len, output int pcw,
                           output logic [1:0] psrc, output int regw, output int nrd, output int nwr);
    len = 0; pcw = 0; psrc = 2'b00; regw = 0; nrd = 0; nwr = 0;
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check($sformatf("op%b_z%0d_cyc%0d", op, z, i), 32'(observe()), 32'(model(op, z, i)));
      if (PCWre) begin pcw++; psrc = PCSrc; end
      if (RegWre) regw++;
      if (mRD) nrd++;
      if (mWR) nwr++;
      len++;
      @(posedge CLK); #1;
      if (state == 4'd0) break;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         len;
    logic [1:0] psrc;
    int         regw;
    int         nrd;
    int         nwr;
  } vec_t;

  vec_t tbl[13];
  int   len, pcw, regw, nrd, nwr;
  logic [1:0] psrc;
  logic [21:0] exp_v;

  initial begin
    tbl[0]  = '{ADD,   1'b0, 4, 2'b00, 1, 0, 0};
    tbl[1]  = '{LW,    1'b0, 5, 2'b00, 1, 1, 0};
    tbl[2]  = '{SW,    1'b0, 4, 2'b00, 0, 0, 1};
    tbl[3]  = '{BEQ,   1'b1, 3, 2'b01, 0, 0, 0};
    tbl[4]  = '{BEQ,   1'b0, 3, 2'b00, 0, 0, 0};
    tbl[5]  = '{BNE,   1'b0, 3, 2'b01, 0, 0, 0};
    tbl[6]  = '{BNE,   1'b1, 3, 2'b00, 0, 0, 0};
    tbl[7]  = '{J,     1'b0, 2, 2'b11, 0, 0, 0};
    tbl[8]  = '{JAL,   1'b0, 2, 2'b11, 1, 0, 0};
    tbl[9]  = '{JR,    1'b0, 2, 2'b10, 0, 0, 0};
    tbl[10] = '{SLL,   1'b1, 4, 2'b00, 1, 0, 0};
    tbl[11] = '{6'b000111, 1'b0, 4, 2'b00, 0, 0, 0};
    tbl[12] = '{ORI,   1'b0, 4, 2'b00, 1, 0, 0};

    // Reset held for two cycles: every output quiet, state reads IF.
    Reset = 1'b1; opcode = ADD; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("reset_cyc%0d", i), 32'(observe()), 32'h0);
      @(posedge CLK); #1;
    end
    Reset = 1'b0;

    foreach (tbl[k]) begin
      run_instr(tbl[k].op, tbl[k].z, len, pcw, psrc, regw, nrd, nwr);
      check($sformatf("tbl%0d_len", k),   32'(len),  32'(tbl[k].len));
      check($sformatf("tbl%0d_pcwre", k), 32'(pcw),  32'd1);
      check($sformatf("tbl%0d_pcsrc", k), 32'(psrc), 32'(tbl[k].psrc));
      check($sformatf("tbl%0d_regwre", k),32'(regw), 32'(tbl[k].regw));
      check($sformatf("tbl%0d_mrd", k),   32'(nrd),  32'(tbl[k].nrd));
      check($sformatf("tbl%0d_mwr", k),   32'(nwr),  32'(tbl[k].nwr));
    end

    // halt: parks in HALT with no enables; Reset brings it back to IF.
    opcode = HALT; zero = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      check($sformatf("halt_cyc%0d", i), 32'(observe()), 32'(model(HALT, 1'b0, i)));
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    @(negedge CLK);
    check("halt_reset_quiet", 32'(observe()), 32'h0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    check("halt_reset_state", 32'(state), 32'd0);
    run_instr(ADD, 1'b0, len, pcw, psrc, regw, nrd, nwr);
    check("after_halt_len", 32'(len), 32'd4);

    // sw with Reset asserted for the whole MEM cycle: no write strobe, no PC pulse.
    opcode = SW; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("swrst_cyc%0d", i), 32'(observe()), 32'(model(SW, 1'b0, i)));
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    @(negedge CLK);
    check("swrst_mem_mwr",   32'(mWR),   32'd0);
    check("swrst_mem_pcwre", 32'(PCWre), 32'd0);
    check("swrst_mem_all",   32'(observe()), 32'h0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    check("swrst_state", 32'(state), 32'd0);
    run_instr(SW, 1'b0, len, pcw, psrc, regw, nrd, nwr);
    check("swrst_next_mwr", 32'(nwr), 32'd1);

    // Unused encoding 12 must fall back to IF on the next edge.
    opcode = ADD; zero = 1'b0;
    force dut.r_state = 4'd12;
    #1;
    release dut.r_state;
    check("illegal_state_seen", 32'(state), 32'd12);
    @(negedge CLK);
    exp_v = model(ADD, 1'b0, 1);
    exp_v[21:18] = 4'd12;
    check("illegal_state_quiet", 32'(observe()), 32'(exp_v));
    @(posedge CLK); #1;
    check("illegal_state_recover", 32'(state), 32'd0);

    // Random instruction stream against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [5:0] pool [16] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                                SLTIU, SW, LW, BEQ, BNE, J, JR, JAL};
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else                           op = pool[$urandom_range(0, 15)];
      if (op == HALT) op = 6'b111110;
      run_instr(op, 1'($urandom_range(0, 1)), len, pcw, psrc, regw, nrd, nwr);
      check($sformatf("rand%0d_len", n), 32'(len), 32'(m_len(op)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
